// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_pkg
// Description : Shared defaults for the dff_pipe elastic pipeline and the
//               helper that sizes the optional occupancy counter.
// Contents    : DFF_PIPE_WIDTH - default payload width
//               DFF_PIPE_DEPTH - default number of register stages
//               occ_width()    - bits needed to count 0..depth valid stages
// Revision    : 1.0 - initial release
// ============================================================================
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH = 8;
  localparam int DFF_PIPE_DEPTH = 4;

  // Counter must represent every value from 0 (empty) to depth (full).
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : dff_pipe_pkg
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_stage
// Description : One elastic pipeline stage: a valid bit, a data register and
//               the ready term telling the upstream side it may send.
// Ports       : clk        - clock, all updates on rising edge
//               reset      - synchronous active-high reset (clears valid+data)
//               flush      - synchronous invalidate (clears valid only)
//               up_valid   - upstream has an item for this stage
//               up_data    - upstream payload
//               down_ready - downstream will take this stage's item
//               valid      - this stage holds an item
//               data       - this stage's payload
//               ready      - this stage accepts an item this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  // Empty, or the held item leaves this cycle: either way the slot frees up.
  assign ready = ~valid | down_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (ready) begin
        valid <= up_valid;
      end
      // Data only moves on a real transfer, so a stalled item stays stable.
      if (!flush && ready && up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule : dff_pipe_stage
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe
// Description : DEPTH-stage elastic valid/ready register pipeline with
//               bubble collapsing, synchronous flush and optional occupancy
//               counter.
// Ports       : clk       - clock
//               reset     - synchronous active-high reset
//               flush     - synchronous invalidate of all stages
//               in_valid  / in_ready  / in_data  - upstream handshake
//               out_valid / out_ready / out_data - downstream handshake
//               occupancy - number of valid stages (DFF_PIPE_COUNT_EN only)
// Config      : define DFF_PIPE_COUNT_EN to build the occupancy port/counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_WIDTH,
  parameter int DEPTH = DFF_PIPE_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef DFF_PIPE_COUNT_EN
  output logic [occ_width(DEPTH)-1:0]  occupancy,
`endif
  output logic [WIDTH-1:0]             out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] down_ready;
  logic [DEPTH-1:0] stage_ready;

  // Stage i may pass its item on when the output drains or any later stage
  // is empty: everything between i and that hole shifts up by one. Deriving
  // this straight from the valid bits avoids a combinational ready chain.
  always_comb begin : p_down_ready
    logic drain;
    down_ready = '0;
    drain      = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      down_ready[i] = drain;
      drain         = drain | ~valid_q[i];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (gi == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = valid_q[gi-1];
      assign up_data  = data_q[gi-1];
    end

    dff_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_ready[gi]),
      .valid      (valid_q[gi]),
      .data       (data_q[gi]),
      .ready      (stage_ready[gi])
    );
  end

  // Only stage 0 faces the outside world; the other ready terms are implied
  // by down_ready and exist for stage self-containment.
  logic unused_stage_ready;
  assign unused_stage_ready = ^stage_ready;

  assign in_ready  = stage_ready[0] & ~flush & ~reset;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

`ifdef DFF_PIPE_COUNT_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] count_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign occupancy = count_q;
`endif

endmodule : dff_pipe
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_pipe
// Description : Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4). A slot
//               array model advances items toward the output each cycle and
//               predicts in_ready, out_valid, out_data and occupancy; directed
//               scenarios are followed by a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef DFF_PIPE_COUNT_EN
  logic [OCC_W-1:0] occupancy;
`endif

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DFF_PIPE_COUNT_EN
    .occupancy (occupancy),
`endif
    .out_data  (out_data)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Model: slot k holds the item that is k stages into the pipe.
  bit             m_v [DEPTH];
  bit [WIDTH-1:0] m_d [DEPTH];

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += int'(m_v[k]);
    return n;
  endfunction

  // Accepts whenever something drains or any slot is free, never in flush/reset.
  function automatic bit m_in_ready(input bit rst, input bit fl, input bit ordy);
    if (rst || fl) return 1'b0;
    if (ordy) return 1'b1;
    return (m_count() < DEPTH);
  endfunction

  // One clock: drive, compare against model, advance model.
  task automatic step(input bit rst, input bit fl, input bit iv,
                      input bit [WIDTH-1:0] id, input bit ordy,
                      output bit acc, output bit emit, output bit [WIDTH-1:0] emit_d);
    bit exp_ir;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    exp_ir = m_in_ready(rst, fl, ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_v[DEPTH-1]});
    if (m_v[DEPTH-1]) check("out_data", 32'(out_data), 32'(m_d[DEPTH-1]));
`ifdef DFF_PIPE_COUNT_EN
    check("occupancy", 32'(occupancy), 32'(m_count()));
`endif
    acc    = iv & exp_ir;
    emit   = m_v[DEPTH-1] & ordy & ~rst;
    emit_d = m_d[DEPTH-1];
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
    end else if (fl) begin
      for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;
    end else begin
      if (m_v[DEPTH-1] && ordy) m_v[DEPTH-1] = 1'b0;
      for (int k = DEPTH - 2; k >= 0; k--) begin
        if (m_v[k] && !m_v[k+1]) begin
          m_v[k+1] = 1'b1; m_d[k+1] = m_d[k]; m_v[k] = 1'b0;
        end
      end
      if (acc) begin m_v[0] = 1'b1; m_d[0] = id; end
    end
    cyc++;
  endtask

  bit             acc, emit;
  bit [WIDTH-1:0] ed;
  int             first_acc, first_emit, n_emit;
  bit [WIDTH-1:0] emitted [$];

  task automatic do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b0, acc, emit, ed);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
    repeat (2) @(posedge clk);

    // Reset then idle
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, acc, emit, ed);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Back-to-back stream 0x01..0x08 with out_ready held high
    first_acc = -1; first_emit = -1; emitted.delete();
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b0, n < 8, (n < 8) ? 8'(n + 1) : 8'h00, 1'b1, acc, emit, ed);
      if (acc && n == 0) first_acc = cyc - 1;
      if (emit) begin
        if (first_emit < 0) first_emit = cyc - 1;
        check("stream_cadence", 32'(cyc - 1), 32'(first_emit + emitted.size()));
        emitted.push_back(ed);
      end
    end
    check("stream_latency", 32'(first_emit - first_acc), 32'(DEPTH));
    check("stream_count", 32'(emitted.size()), 32'd8);
    foreach (emitted[k]) check("stream_order", 32'(emitted[k]), 32'(k + 1));

    // Fill with out_ready low, hold, then drain
    do_reset();
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b1, 8'(n + 1), 1'b0, acc, emit, ed);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, acc, emit, ed);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_hold_data", 32'(out_data), 32'h01);
`ifdef DFF_PIPE_COUNT_EN
      check("full_occupancy", 32'(occupancy), 32'd4);
`endif
    end
    emitted.delete();
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, acc, emit, ed);
      if (emit) emitted.push_back(ed);
    end
    check("drain_count", 32'(emitted.size()), 32'd4);
    foreach (emitted[k]) check("drain_order", 32'(emitted[k]), 32'(k + 1));

    // Full pipe: simultaneous entry and exit
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b1, 8'(8'h10 + n), 1'b0, acc, emit, ed);
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'h20 + n), 1'b1, acc, emit, ed);
      check("full_pass_both", {30'd0, acc, emit}, 32'd3);
      check("full_pass_data", 32'(ed), 32'(8'h10 + n));
    end
`ifdef DFF_PIPE_COUNT_EN
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, acc, emit, ed);
    check("full_pass_occ", 32'(occupancy), 32'd4);
`endif

    // Flush with 3 items in flight and an input offered in the flush cycle
    do_reset();
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1, 8'(8'h30 + n), 1'b0, acc, emit, ed);
    step(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, acc, emit, ed);
    check("flush_accept", {31'd0, acc}, 32'd0);
    n_emit = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, acc, emit, ed);
      if (n == 0) check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      n_emit += int'(emit);
    end
    check("flush_no_emit", 32'(n_emit), 32'd0);

    // Reset asserted mid-stream with out_ready low
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1, 8'(8'h40 + n), 1'b0, acc, emit, ed);
    step(1'b1, 1'b1, 1'b1, 8'hBB, 1'b0, acc, emit, ed);
    n_emit = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, acc, emit, ed);
      n_emit += int'(emit);
    end
    check("midrst_no_emit", 32'(n_emit), 32'd0);

    // Randomized soak
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
           acc, emit, ed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dff_pipe
`default_nettype wire

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data bit width (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of register stages (>=1).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge clk.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The module SHALL have port flush, input, 1 bit, a synchronous pipeline invalidate.
REQ-006 The module SHALL have port in_valid, input, 1 bit, indicating upstream data is present.
REQ-007 The module SHALL have port in_ready, output, 1 bit, indicating stage 0 accepts this cycle.
REQ-008 The module SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-009 The module SHALL have port out_valid, output, 1 bit, equal to the stage DEPTH-1 valid bit.
REQ-010 The module SHALL have port out_ready, input, 1 bit, indicating downstream accepts this cycle.
REQ-011 The module SHALL have port out_data, output, WIDTH bits, equal to the stage DEPTH-1 data.
REQ-012 Under the count feature, the module SHALL have port occupancy, output, $clog2(DEPTH+1) bits, giving the number of valid stages.

Function
REQ-013 The module SHALL implement an elastic pipeline of DEPTH stages, each holding valid_i and data_i.
REQ-014 A transfer SHALL occur at a boundary when the sender's valid and the receiver's ready are both 1 on a posedge.
REQ-015 Stage i SHALL be ready when valid_i==0 or stage i transfers out in the same cycle; the last stage's outflow is out_ready.
REQ-016 in_ready SHALL equal stage 0 ready AND NOT flush, so in_ready is 0 whenever flush is 1.
REQ-017 With no stalls, data accepted in cycle N SHALL appear with out_valid=1 at cycle N+DEPTH.
REQ-018 At full throughput the pipeline SHALL sustain one transfer per cycle.
REQ-019 Bubbles SHALL collapse: a stalled output SHALL NOT block earlier stages from advancing into empty stages.
REQ-020 A stage holding valid data that cannot advance SHALL keep its data stable until it transfers.
REQ-021 out_data SHALL NOT change while out_valid=1 and out_ready=0.
REQ-022 Item order SHALL be preserved with no duplication and no loss except on flush or reset.
REQ-023 Flush=1 SHALL clear every valid bit at the next posedge; data registers MAY retain their values.
REQ-024 An in_valid arriving in a flush cycle SHALL be dropped.
REQ-025 When the pipeline is full and out_ready=1, in_ready SHALL be 1, allowing simultaneous entry and exit.

Reset
REQ-026 On reset=1 at posedge, every valid_i SHALL be 0, every data_i SHALL be 0, out_valid SHALL be 0, and occupancy SHALL be 0.
REQ-027 During reset, in_ready SHALL be 0.
REQ-028 Reset SHALL take priority over flush and all transfers, including a reset asserted mid-stream.

Configuration
REQ-029 With macro DFF_PIPE_COUNT_EN defined, the occupancy port and counter SHALL exist.
REQ-030 The counter SHALL track +1 on input transfer, -1 on output transfer, net 0 on both, and 0 on flush.
REQ-031 Without DFF_PIPE_COUNT_EN, the port and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 A shared package dff_pipe_pkg SHALL hold the WIDTH/DEPTH defaults and an occupancy-width function.
REQ-033 A sub-module dff_pipe_stage (one valid+data register with ready logic) SHALL be instantiated DEPTH times via generate.

Verification
REQ-034 Reset then idle: out_valid=0, in_ready=1, and occupancy=0.
REQ-035 DEPTH=4, out_ready=1, stream 0x01..0x08 back-to-back: 0x01 appears 4 cycles after acceptance, and one item is output per cycle in order.
REQ-036 Fill with out_ready=0: after 4 accepts in_ready=0, occupancy=4, and out_data holds 0x01 stable; raising out_ready drains 0x01..0x04.
REQ-037 Full pipeline with out_ready=1 and in_valid=1: entry and exit occur in the same cycle and occupancy stays 4.
REQ-038 Flush with 3 items in flight and in_valid=1: next cycle out_valid=0, occupancy=0, and the input item is never output.
REQ-039 Reset asserted mid-stream with out_ready=0: all valids are 0 the next cycle, and no stale item emerges after reset is released.
